gam_node_memory: RTL and testbench

Clocked, parametrised node store for the GAM learning layers: NUM_CLASSES classes × NODES_PER_CLASS nodes, each holding prototype vector X, weight vector W, threshold Th and match count M. It replaces the combinational class/node memory with a single-port valid/ready request/response interface. It adds per-field write masking, hardware free-node allocation, multi-cycle class clear and per-class occupancy tracking. It sits between the GAM learning controller and the classifier datapath.

---
 rtl/gam_node_memory_pkg.sv | 30 +++
 rtl/gam_node_memory_if.sv | 50 +++++
 rtl/gam_node_memory_finder.sv | 24 ++
 rtl/gam_node_memory.sv | 209 ++++++++++++++++++++
 tb/tb_gam_node_memory.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gam_node_memory_pkg.sv
// Shared types for the GAM node store: opcodes, FSM states,
// field-mask bit positions and default geometry.
package gam_node_memory_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ALLOC = 2'd2,
        OP_CLEAR = 2'd3
    } gam_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CLR,
        S_RESP
    } gam_state_t;

    localparam int MASK_X  = 0;
    localparam int MASK_W  = 1;
    localparam int MASK_TH = 2;
    localparam int MASK_M  = 3;

    localparam int DEF_NUM_CLASSES     = 8;
    localparam int DEF_NODES_PER_CLASS = 16;
    localparam int DEF_VEC_LEN         = 4;
    localparam int DEF_ELEM_W          = 16;
    localparam int DEF_SCALAR_W        = 32;

endpackage

// File: rtl/gam_node_memory_if.sv
// Request/response handshake bundle between the GAM learning
// controller (master) and the node store (slave).
interface gam_node_memory_if
    import gam_node_memory_pkg::*;
#(
    parameter int CW       = 3,
    parameter int NW       = 4,
    parameter int VEC_LEN  = 4,
    parameter int ELEM_W   = 16,
    parameter int SCALAR_W = 32
);
    localparam int DW = VEC_LEN * ELEM_W;

    logic                req_valid;
    logic                req_ready;
    gam_op_t             req_op;
    logic [3:0]          req_mask;
    logic [CW-1:0]       req_class;
    logic [NW-1:0]       req_node;
    logic [DW-1:0]       req_x;
    logic [DW-1:0]       req_w;
    logic [SCALAR_W-1:0] req_th;
    logic [SCALAR_W-1:0] req_m;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DW-1:0]       rsp_x;
    logic [DW-1:0]       rsp_w;
    logic [SCALAR_W-1:0] rsp_th;
    logic [SCALAR_W-1:0] rsp_m;
    logic [NW-1:0]       rsp_node;
    logic                rsp_hit;
    logic                rsp_err;
    logic [NW:0]         rsp_count;

    modport master (
        output req_valid, req_op, req_mask, req_class, req_node,
        output req_x, req_w, req_th, req_m, rsp_ready,
        input  req_ready, rsp_valid, rsp_x, rsp_w, rsp_th, rsp_m,
        input  rsp_node, rsp_hit, rsp_err, rsp_count
    );

    modport slave (
        input  req_valid, req_op, req_mask, req_class, req_node,
        input  req_x, req_w, req_th, req_m, rsp_ready,
        output req_ready, rsp_valid, rsp_x, rsp_w, rsp_th, rsp_m,
        output rsp_node, rsp_hit, rsp_err, rsp_count
    );

endinterface

// File: rtl/gam_node_memory_finder.sv
// Priority encoder over one class's valid bits: lowest free
// node index plus a full flag.
module gam_free_node_finder #(
    parameter int N  = 16,
    parameter int NW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    output logic [NW-1:0] free_idx,
    output logic          full
);

    always_comb begin
        free_idx = '0;
        full     = 1'b1;
        // Scan downward so the lowest free index wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = NW'(i);
                full     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gam_node_memory.sv
// GAM class/node store: X, W, Th, M per node with masked writes,
// free-node allocation, walking class clear and occupancy counts.
module gam_node_memory
    import gam_node_memory_pkg::*;
#(
    parameter int NUM_CLASSES     = DEF_NUM_CLASSES,
    parameter int NODES_PER_CLASS = DEF_NODES_PER_CLASS,
    parameter int VEC_LEN         = DEF_VEC_LEN,
    parameter int ELEM_W          = DEF_ELEM_W,
    parameter int SCALAR_W        = DEF_SCALAR_W
) (
    input logic             clk,
    input logic             rst_n,
    gam_node_memory_if.slave bus
);

    localparam int CW = $clog2(NUM_CLASSES);
    localparam int NW = $clog2(NODES_PER_CLASS);
    localparam int DW = VEC_LEN * ELEM_W;

    localparam logic [CW:0]   CLS_LIM  = (CW+1)'(NUM_CLASSES);
    localparam logic [NW:0]   NODE_LIM = (NW+1)'(NODES_PER_CLASS);
    localparam logic [NW-1:0] LAST     = NW'(NODES_PER_CLASS - 1);
    localparam logic [NW:0]   OCC_ONE  = (NW+1)'(1);

    logic [DW-1:0]              x_mem  [NUM_CLASSES][NODES_PER_CLASS];
    logic [DW-1:0]              w_mem  [NUM_CLASSES][NODES_PER_CLASS];
    logic [SCALAR_W-1:0]        th_mem [NUM_CLASSES][NODES_PER_CLASS];
    logic [SCALAR_W-1:0]        m_mem  [NUM_CLASSES][NODES_PER_CLASS];
    logic [NODES_PER_CLASS-1:0] vld    [NUM_CLASSES];
    logic [NW:0]                occ    [NUM_CLASSES];

    gam_state_t          state;
    gam_op_t             op_q;
    logic [3:0]          mask_q;
    logic [CW-1:0]       cls_q;
    logic [NW-1:0]       node_q;
    logic [DW-1:0]       x_q;
    logic [DW-1:0]       w_q;
    logic [SCALAR_W-1:0] th_q;
    logic [SCALAR_W-1:0] m_q;
    logic [NW-1:0]       clr_idx;

    logic          cls_bad;
    logic          node_bad;
    logic          addr_op;
    logic [NW-1:0] free_idx;
    logic          full;

    assign bus.req_ready = (state == S_IDLE);
    assign cls_bad  = {1'b0, bus.req_class} >= CLS_LIM;
    assign node_bad = {1'b0, bus.req_node} >= NODE_LIM;
    assign addr_op  = (bus.req_op == OP_READ) || (bus.req_op == OP_WRITE);

    gam_free_node_finder #(
        .N  (NODES_PER_CLASS),
        .NW (NW)
    ) u_finder (
        .valid    (vld[cls_q]),
        .free_idx (free_idx),
        .full     (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= OP_READ;
            mask_q  <= '0;
            cls_q   <= '0;
            node_q  <= '0;
            x_q     <= '0;
            w_q     <= '0;
            th_q    <= '0;
            m_q     <= '0;
            clr_idx <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                vld[c] <= '0;
                occ[c] <= '0;
                for (int n = 0; n < NODES_PER_CLASS; n++) begin
                    x_mem[c][n]  <= '0;
                    w_mem[c][n]  <= '0;
                    th_mem[c][n] <= '0;
                    m_mem[c][n]  <= '0;
                end
            end
            bus.rsp_valid <= 1'b0;
            bus.rsp_x     <= '0;
            bus.rsp_w     <= '0;
            bus.rsp_th    <= '0;
            bus.rsp_m     <= '0;
            bus.rsp_node  <= '0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_count <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        mask_q  <= bus.req_mask;
                        cls_q   <= bus.req_class;
                        node_q  <= bus.req_node;
                        x_q     <= bus.req_x;
                        w_q     <= bus.req_w;
                        th_q    <= bus.req_th;
                        m_q     <= bus.req_m;
                        clr_idx <= '0;
                        if (cls_bad || (addr_op && node_bad)) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_hit   <= 1'b0;
                            bus.rsp_x     <= '0;
                            bus.rsp_w     <= '0;
                            bus.rsp_th    <= '0;
                            bus.rsp_m     <= '0;
                            bus.rsp_node  <= '0;
                            bus.rsp_count <= cls_bad ? '0 : occ[bus.req_class];
                            state         <= S_RESP;
                        end else if (bus.req_op == OP_CLEAR) begin
                            state <= S_CLR;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_hit   <= 1'b0;
                    bus.rsp_x     <= '0;
                    bus.rsp_w     <= '0;
                    bus.rsp_th    <= '0;
                    bus.rsp_m     <= '0;
                    bus.rsp_node  <= node_q;
                    bus.rsp_count <= occ[cls_q];
                    state         <= S_RESP;
                    case (op_q)
                        OP_READ: begin
                            bus.rsp_hit <= vld[cls_q][node_q];
                            if (mask_q[MASK_X])  bus.rsp_x  <= x_mem[cls_q][node_q];
                            if (mask_q[MASK_W])  bus.rsp_w  <= w_mem[cls_q][node_q];
                            if (mask_q[MASK_TH]) bus.rsp_th <= th_mem[cls_q][node_q];
                            if (mask_q[MASK_M])  bus.rsp_m  <= m_mem[cls_q][node_q];
                        end
                        OP_WRITE: begin
                            bus.rsp_hit <= vld[cls_q][node_q];
                            if (mask_q[MASK_X])  x_mem[cls_q][node_q]  <= x_q;
                            if (mask_q[MASK_W])  w_mem[cls_q][node_q]  <= w_q;
                            if (mask_q[MASK_TH]) th_mem[cls_q][node_q] <= th_q;
                            if (mask_q[MASK_M])  m_mem[cls_q][node_q]  <= m_q;
                            vld[cls_q][node_q] <= 1'b1;
                            if (!vld[cls_q][node_q]) begin
                                occ[cls_q]    <= occ[cls_q] + OCC_ONE;
                                bus.rsp_count <= occ[cls_q] + OCC_ONE;
                            end
                        end
                        OP_ALLOC: begin
                            if (full) begin
                                bus.rsp_err  <= 1'b1;
                                bus.rsp_node <= '0;
                            end else begin
                                // Fresh slot: unmasked fields start from zero.
                                x_mem[cls_q][free_idx]  <= mask_q[MASK_X]  ? x_q  : '0;
                                w_mem[cls_q][free_idx]  <= mask_q[MASK_W]  ? w_q  : '0;
                                th_mem[cls_q][free_idx] <= mask_q[MASK_TH] ? th_q : '0;
                                m_mem[cls_q][free_idx]  <= mask_q[MASK_M]  ? m_q  : '0;
                                vld[cls_q][free_idx]    <= 1'b1;
                                occ[cls_q]    <= occ[cls_q] + OCC_ONE;
                                bus.rsp_node  <= free_idx;
                                bus.rsp_count <= occ[cls_q] + OCC_ONE;
                            end
                        end
                        default: ;
                    endcase
                end
                S_CLR: begin
                    x_mem[cls_q][clr_idx]  <= '0;
                    w_mem[cls_q][clr_idx]  <= '0;
                    th_mem[cls_q][clr_idx] <= '0;
                    m_mem[cls_q][clr_idx]  <= '0;
                    vld[cls_q][clr_idx]    <= 1'b0;
                    if (clr_idx == LAST) begin
                        occ[cls_q]    <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_hit   <= 1'b0;
                        bus.rsp_x     <= '0;
                        bus.rsp_w     <= '0;
                        bus.rsp_th    <= '0;
                        bus.rsp_m     <= '0;
                        bus.rsp_node  <= '0;
                        bus.rsp_count <= '0;
                        state         <= S_RESP;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gam_node_memory.sv
// Randomised and directed bench for gam_node_memory against a
// behavioural array model of the class/node store.
module tb_gam_node_memory;
    import gam_node_memory_pkg::*;

    localparam int NC  = 6;
    localparam int NPC = 16;

    typedef struct packed {
        logic [63:0] x;
        logic [63:0] w;
        logic [31:0] th;
        logic [31:0] m;
        logic [3:0]  node;
        logic        hit;
        logic        err;
        logic [4:0]  count;
    } rsp_s;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [63:0] mx  [NC][NPC];
    logic [63:0] mw  [NC][NPC];
    logic [31:0] mth [NC][NPC];
    logic [31:0] mm  [NC][NPC];
    bit          mv  [NC][NPC];

    always #5 clk = ~clk;

    gam_node_memory_if #(
        .CW(3), .NW(4), .VEC_LEN(4), .ELEM_W(16), .SCALAR_W(32)
    ) bif ();

    gam_node_memory #(
        .NUM_CLASSES(NC), .NODES_PER_CLASS(NPC),
        .VEC_LEN(4), .ELEM_W(16), .SCALAR_W(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    function automatic void model_reset();
        for (int c = 0; c < NC; c++)
            for (int n = 0; n < NPC; n++) begin
                mx[c][n] = '0; mw[c][n] = '0;
                mth[c][n] = '0; mm[c][n] = '0; mv[c][n] = 0;
            end
    endfunction

    function automatic int occupancy(input int c);
        int k = 0;
        for (int n = 0; n < NPC; n++) k += int'(mv[c][n]);
        return k;
    endfunction

    function automatic void model(input int op, input logic [3:0] mask,
                                  input int c, input int n,
                                  input logic [63:0] x, input logic [63:0] w,
                                  input logic [31:0] th, input logic [31:0] m,
                                  output rsp_s e, output int lat);
        int f;
        e = '0;
        lat = 2;
        if (c >= NC) begin
            e.err = 1'b1;
            lat = 1;
            return;
        end
        case (op)
            0: begin
                e.node = 4'(n);
                e.hit = mv[c][n];
                e.x  = mask[0] ? mx[c][n]  : '0;
                e.w  = mask[1] ? mw[c][n]  : '0;
                e.th = mask[2] ? mth[c][n] : '0;
                e.m  = mask[3] ? mm[c][n]  : '0;
            end
            1: begin
                e.node = 4'(n);
                e.hit = mv[c][n];
                if (mask[0]) mx[c][n] = x;
                if (mask[1]) mw[c][n] = w;
                if (mask[2]) mth[c][n] = th;
                if (mask[3]) mm[c][n] = m;
                mv[c][n] = 1;
            end
            2: begin
                f = -1;
                for (int i = NPC - 1; i >= 0; i--) if (!mv[c][i]) f = i;
                if (f < 0) e.err = 1'b1;
                else begin
                    mx[c][f]  = mask[0] ? x  : '0;
                    mw[c][f]  = mask[1] ? w  : '0;
                    mth[c][f] = mask[2] ? th : '0;
                    mm[c][f]  = mask[3] ? m  : '0;
                    mv[c][f]  = 1;
                    e.node = 4'(f);
                end
            end
            default: begin
                for (int i = 0; i < NPC; i++) begin
                    mx[c][i] = '0; mw[c][i] = '0;
                    mth[c][i] = '0; mm[c][i] = '0; mv[c][i] = 0;
                end
                lat = NPC + 1;
            end
        endcase
        e.count = 5'(occupancy(c));
    endfunction

    task automatic do_req(input int op, input logic [3:0] mask,
                          input int c, input int n,
                          input logic [63:0] x, input logic [63:0] w,
                          input logic [31:0] th, input logic [31:0] m,
                          input int hold, output rsp_s r,
                          output int lat, output bit stable);
        int t = 0;
        rsp_s h;
        stable = 1;
        @(negedge clk);
        bif.req_op = gam_op_t'(op);
        bif.req_mask = mask;
        bif.req_class = 3'(c);
        bif.req_node = 4'(n);
        bif.req_x = x; bif.req_w = w;
        bif.req_th = th; bif.req_m = m;
        bif.req_valid = 1'b1;
        while (!bif.req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!bif.req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout req_ready=%0b required 1", bif.req_ready);
        end
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        lat = 1;
        while (!bif.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        r = {bif.rsp_x, bif.rsp_w, bif.rsp_th, bif.rsp_m,
             bif.rsp_node, bif.rsp_hit, bif.rsp_err, bif.rsp_count};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            h = {bif.rsp_x, bif.rsp_w, bif.rsp_th, bif.rsp_m,
                 bif.rsp_node, bif.rsp_hit, bif.rsp_err, bif.rsp_count};
            if (h !== r || bif.rsp_valid !== 1'b1) stable = 0;
        end
        bif.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bif.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rsp_s r, e;
        int lat, elat;
        bit st;
        checks++;
        if (bif.req_ready !== 1'b1 || bif.rsp_valid !== 1'b0 ||
            bif.rsp_count !== 5'd0 || bif.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b valid=%b count=%0d err=%b required 1 0 0 0",
                     bif.req_ready, bif.rsp_valid, bif.rsp_count, bif.rsp_err);
        end
        model(0, 4'hF, 0, 0, '0, '0, '0, '0, e, elat);
        do_req(0, 4'hF, 0, 0, '0, '0, '0, '0, 0, r, lat, st);
        checks++;
        if (r !== e || e !== rsp_s'(0)) begin
            errors++;
            $display("FAIL reset_read got=%h required=%h", r, e);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL read_latency got=%0d required=2", lat);
        end
    endtask

    task automatic test_write_read();
        rsp_s r, e;
        int lat, elat;
        bit st;
        logic [63:0] xv = {16'd4, 16'd3, 16'd2, 16'd1};
        logic [63:0] wv = {4{16'd7}};
        model(1, 4'b0101, 2, 5, xv, wv, 32'd100, 32'd0, e, elat);
        do_req(1, 4'b0101, 2, 5, xv, wv, 32'd100, 32'd0, 0, r, lat, st);
        checks++;
        if (r !== e || lat !== elat) begin
            errors++;
            $display("FAIL write_rsp got=%h lat=%0d required=%h lat=%0d", r, lat, e, elat);
        end
        model(0, 4'hF, 2, 5, '0, '0, '0, '0, e, elat);
        do_req(0, 4'hF, 2, 5, '0, '0, '0, '0, 0, r, lat, st);
        checks++;
        if (r.x !== xv || r.w !== 64'd0 || r.th !== 32'd100 ||
            r.m !== 32'd0 || r.hit !== 1'b1 || r.count !== 5'd1) begin
            errors++;
            $display("FAIL write_readback got=%h required x=%h th=100 hit=1 count=1", r, xv);
        end
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL write_readback_model got=%h required=%h", r, e);
        end
    endtask

    task automatic test_alloc_fill();
        rsp_s r, e;
        int lat, elat;
        bit st;
        int bad = 0;
        for (int i = 0; i < NPC; i++) begin
            model(2, 4'b1000, 3, 0, '0, '0, '0, 32'(i + 1), e, elat);
            do_req(2, 4'b1000, 3, 0, '0, '0, '0, 32'(i + 1), 0, r, lat, st);
            checks++;
            if (r !== e || r.node !== 4'(i) || r.count !== 5'(i + 1)) begin
                errors++;
                $display("FAIL alloc_%0d got=%h required node=%0d count=%0d", i, r, i, i + 1);
            end
        end
        model(2, 4'hF, 3, 0, '1, '1, '1, '1, e, elat);
        do_req(2, 4'hF, 3, 0, '1, '1, '1, '1, 0, r, lat, st);
        checks++;
        if (r.err !== 1'b1 || r.count !== 5'd16 || r !== e) begin
            errors++;
            $display("FAIL alloc_full got=%h required err=1 count=16", r);
        end
        if (bad != 0) errors++;
    endtask

    task automatic test_clear_hold();
        rsp_s r, e;
        int lat, elat;
        bit st;
        model(3, 4'h0, 3, 0, '0, '0, '0, '0, e, elat);
        do_req(3, 4'h0, 3, 0, '0, '0, '0, '0, 5, r, lat, st);
        checks++;
        if (lat !== 17 || r !== e || r.count !== 5'd0) begin
            errors++;
            $display("FAIL clear_rsp lat=%0d got=%h required lat=17 %h", lat, r, e);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL clear_hold_stable got=0 required=1");
        end
        model(2, 4'h0, 3, 0, '0, '0, '0, '0, e, elat);
        do_req(2, 4'h0, 3, 0, '0, '0, '0, '0, 0, r, lat, st);
        checks++;
        if (r.node !== 4'd0 || r.count !== 5'd1 || r !== e) begin
            errors++;
            $display("FAIL alloc_after_clear got=%h required node=0 count=1", r);
        end
    endtask

    task automatic test_reject();
        rsp_s r, e;
        int lat, elat;
        bit st;
        model(1, 4'hF, 7, 5, '1, '1, '1, '1, e, elat);
        do_req(1, 4'hF, 7, 5, '1, '1, '1, '1, 0, r, lat, st);
        checks++;
        if (r.err !== 1'b1 || lat !== 1 || r !== e) begin
            errors++;
            $display("FAIL reject_class got=%h lat=%0d required err=1 lat=1", r, lat);
        end
        model(0, 4'hF, 2, 5, '0, '0, '0, '0, e, elat);
        do_req(0, 4'hF, 2, 5, '0, '0, '0, '0, 0, r, lat, st);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL reject_no_change got=%h required=%h", r, e);
        end
    endtask

    task automatic test_random();
        rsp_s r, e;
        int lat, elat, op, c, n, sel;
        bit st;
        logic [3:0] mask;
        logic [63:0] x, w;
        logic [31:0] th, m;
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 11));
            op = sel < 4 ? 0 : sel < 7 ? 1 : sel < 11 ? 2 : 3;
            c = int'($urandom_range(0, 7));
            n = int'($urandom_range(0, NPC - 1));
            mask = 4'($urandom);
            x = {$urandom, $urandom};
            w = {$urandom, $urandom};
            th = $urandom;
            m = $urandom;
            model(op, mask, c, n, x, w, th, m, e, elat);
            do_req(op, mask, c, n, x, w, th, m,
                   int'($urandom_range(0, 2)), r, lat, st);
            checks++;
            if (r !== e || lat !== elat || !st) begin
                errors++;
                $display("FAIL random_%0d op=%0d c=%0d n=%0d got=%h lat=%0d st=%0b required=%h lat=%0d",
                         i, op, c, n, r, lat, st, e, elat);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        rsp_s r, e;
        int lat, elat;
        bit st;
        int bad = 0;
        for (int i = 0; i < 12; i++) begin
            model(2, 4'hF, 4, 0, 64'(i + 9), 64'(i), 32'(i), 32'(i), e, elat);
            do_req(2, 4'hF, 4, 0, 64'(i + 9), 64'(i), 32'(i), 32'(i), 0, r, lat, st);
        end
        model(1, 4'hF, 4, 14, '1, '1, '1, '1, e, elat);
        do_req(1, 4'hF, 4, 14, '1, '1, '1, '1, 0, r, lat, st);
        @(negedge clk);
        bif.req_op = OP_CLEAR;
        bif.req_class = 3'd4;
        bif.req_valid = 1'b1;
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bif.rsp_valid !== 1'b0 || bif.rsp_count !== 5'd0 ||
            bif.rsp_x !== 64'd0 || bif.rsp_err !== 1'b0 ||
            bif.rsp_hit !== 1'b0 || bif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_clear valid=%b count=%0d err=%b ready=%b required 0 0 0 1",
                     bif.rsp_valid, bif.rsp_count, bif.rsp_err, bif.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 9; n < NPC; n++) begin
            model(0, 4'hF, 4, n, '0, '0, '0, '0, e, elat);
            do_req(0, 4'hF, 4, n, '0, '0, '0, '0, 0, r, lat, st);
            checks++;
            if (r !== e || r.hit !== 1'b0 || r.x !== 64'd0) begin
                errors++;
                $display("FAIL post_reset_node_%0d got=%h required=%h", n, r, e);
            end
        end
        if (bad != 0) errors++;
    endtask

    initial begin
        bif.req_valid = 1'b0;
        bif.req_op = OP_READ;
        bif.req_mask = '0;
        bif.req_class = '0;
        bif.req_node = '0;
        bif.req_x = '0;
        bif.req_w = '0;
        bif.req_th = '0;
        bif.req_m = '0;
        bif.rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_alloc_fill();
        test_clear_hold();
        test_reject();
        test_random();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
